// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Fetch stage in front of a combinational instruction ROM.
//                Drives the ROM address from a registered PC and latches the
//                returned 9-bit word {format, immediate} into an instruction
//                register with decoded fields. Handles stall, branch redirect
//                and halt detection.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1      rising-edge clock
//    reset          in   1      synchronous, active-high
//    stall          in   1      hold PC and IR this cycle
//    branch_taken   in   1      redirect PC to branch_target
//    branch_target  in   PC_W   redirect address
//    pc_out         out  PC_W   registered PC, drives ROM address
//    rom_format     in   1      ROM word[8]
//    rom_immediate  in   8      ROM word[7:0]
//    ir_valid       out  1      IR holds a live instruction
//    ir_format      out  1      IR word[8]
//    ir_opcode      out  4      IR word[7:4]
//    ir_sign        out  1      IR word[3]
//    ir_operand     out  3      IR word[2:0]
//    ir_immediate   out  8      IR word[7:0]
//    ir_pc          out  PC_W   address the IR word came from
//    halted         out  1      halt word fetched, fetch frozen
//    fetch_count    out  CNT_W  saturating count of IR loads
// ============================================================================
module instr_fetch #(
  parameter int          PC_W      = 16,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [8:0]  HALT_WORD = 9'h1B0,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   pc_out,
  input  logic              rom_format,
  input  logic [7:0]        rom_immediate,
  output logic              ir_valid,
  output logic              ir_format,
  output logic [3:0]        ir_opcode,
  output logic              ir_sign,
  output logic [2:0]        ir_operand,
  output logic [7:0]        ir_immediate,
  output logic [PC_W-1:0]   ir_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [8:0]        ir_word_q, ir_word_d;
  logic [PC_W-1:0]   ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [8:0]        rom_word;

  assign rom_word = {rom_format, rom_immediate};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC[PC_W-1:0];
      ir_word_q  <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_word_q  <= ir_word_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_word_d  = ir_word_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_RUN: begin
        if (branch_taken) begin
          // The word at the old PC is discarded; branch beats stall.
          pc_d       = branch_target;
          ir_valid_d = 1'b0;
        end else if (!stall) begin
          ir_word_d  = rom_word;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          if (cnt_q != C_CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          // The halt word is loaded but the PC stays on it.
          if (rom_word == HALT_WORD) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      S_HALT: begin
        // Everything frozen; the halt instruction is presented for one cycle only.
        ir_valid_d = 1'b0;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign pc_out       = pc_q;
  assign ir_valid     = ir_valid_q;
  assign ir_format    = ir_word_q[8];
  assign ir_immediate = ir_word_q[7:0];
  assign ir_opcode    = ir_word_q[7:4];
  assign ir_sign      = ir_word_q[3];
  assign ir_operand   = ir_word_q[2:0];
  assign ir_pc        = ir_pc_q;
  assign halted       = (state_q == S_HALT);
  assign fetch_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. A behavioural fetch
//                model follows the same stimulus; directed scenarios are
//                followed by a randomized phase. A second instance with a
//                2-bit counter exercises counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [8:0] HALT = 9'h1B0;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc_out, ir_pc;
  logic        rom_format, ir_valid, ir_format, ir_sign, halted;
  logic [7:0]  rom_immediate, ir_immediate;
  logic [3:0]  ir_opcode;
  logic [2:0]  ir_operand;
  logic [15:0] fetch_count;

  // second instance: 2-bit counter
  logic        reset2, stall2;
  logic [15:0] pc_out2, ir_pc2;
  logic        ir_valid2, ir_format2, ir_sign2, halted2;
  logic [7:0]  ir_immediate2;
  logic [3:0]  ir_opcode2;
  logic [2:0]  ir_operand2;
  logic [1:0]  fetch_count2;

  logic [8:0]  rom [256];
  logic [8:0]  rom_word2;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [15:0] m_pc, m_irpc;
  logic [8:0]  m_word;
  logic        m_valid, m_halted;
  int          m_cnt;

  always #5 clk = ~clk;

  assign {rom_format, rom_immediate} = rom[pc_out[7:0]];
  assign rom_word2 = rom[pc_out2[7:0]];

  instr_fetch #(.PC_W(16), .RESET_PC(16'h0000), .HALT_WORD(HALT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_out(pc_out),
    .rom_format(rom_format), .rom_immediate(rom_immediate),
    .ir_valid(ir_valid), .ir_format(ir_format), .ir_opcode(ir_opcode),
    .ir_sign(ir_sign), .ir_operand(ir_operand), .ir_immediate(ir_immediate),
    .ir_pc(ir_pc), .halted(halted), .fetch_count(fetch_count)
  );

  instr_fetch #(.PC_W(16), .RESET_PC(16'h0000), .HALT_WORD(HALT), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .stall(stall2), .branch_taken(1'b0),
    .branch_target(16'h0000), .pc_out(pc_out2),
    .rom_format(rom_word2[8]), .rom_immediate(rom_word2[7:0]),
    .ir_valid(ir_valid2), .ir_format(ir_format2), .ir_opcode(ir_opcode2),
    .ir_sign(ir_sign2), .ir_operand(ir_operand2), .ir_immediate(ir_immediate2),
    .ir_pc(ir_pc2), .halted(halted2), .fetch_count(fetch_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the fetch stage described in plain terms.
  task automatic model_step();
    logic [8:0] w;
    if (reset) begin
      m_pc = 16'h0000; m_valid = 1'b0; m_word = '0; m_irpc = '0;
      m_halted = 1'b0; m_cnt = 0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (branch_taken) begin
      m_pc = branch_target; m_valid = 1'b0;
    end else if (!stall) begin
      w = rom[m_pc[7:0]];
      m_word  = w;
      m_irpc  = m_pc;
      m_valid = 1'b1;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (w == HALT) m_halted = 1'b1;
      else m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic check_all();
    chk("pc_out",       pc_out,       m_pc);
    chk("ir_valid",     ir_valid,     m_valid);
    chk("ir_format",    ir_format,    m_word[8]);
    chk("ir_opcode",    ir_opcode,    m_word[7:4]);
    chk("ir_sign",      ir_sign,      m_word[3]);
    chk("ir_operand",   ir_operand,   m_word[2:0]);
    chk("ir_immediate", ir_immediate, m_word[7:0]);
    chk("ir_pc",        ir_pc,        m_irpc);
    chk("halted",       halted,       m_halted);
    chk("fetch_count",  fetch_count,  m_cnt);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    logic [8:0] w;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    reset2 = 1'b1; stall2 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = 9'($urandom_range(0, 511));
      if (w == HALT) w = 9'h001;
      rom[i] = w;
    end
    rom[0] = 9'h000; rom[1] = 9'h178; rom[2] = 9'h080; rom[3] = 9'h179;
    rom[121] = HALT;

    // reset state
    cyc(); cyc();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_cnt", fetch_count, 32'h0);
    reset = 1'b0;

    // sequential fetch of words 0..3
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("seq_ir_pc", ir_pc, i);
      if (i == 1) begin
        chk("w1_opcode", ir_opcode, 32'h7);
        chk("w1_sign", ir_sign, 32'h1);
        chk("w1_operand", ir_operand, 32'h0);
      end
    end
    chk("seq_count", fetch_count, 32'd4);

    // stall at pc 5
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", pc_out, 32'd5);
      chk("stall_cnt", fetch_count, 32'd5);
    end
    stall = 1'b0;
    cyc();
    chk("resume_ir", {ir_format, ir_immediate}, rom[5]);

    // branch with simultaneous stall at pc 10
    repeat (4) cyc();
    chk("pre_br_pc", pc_out, 32'd10);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
    cyc();
    chk("br_pc", pc_out, 32'h40);
    chk("br_valid", ir_valid, 32'h0);
    stall = 1'b0; branch_taken = 1'b0;
    cyc();
    chk("br_ir_pc", ir_pc, 32'h40);

    // halt at pc 121
    branch_taken = 1'b1; branch_target = 16'd120;
    cyc();
    branch_taken = 1'b0;
    cyc(); cyc();
    chk("halt_flag", halted, 32'h1);
    chk("halt_word", {ir_format, ir_immediate}, HALT);
    chk("halt_valid", ir_valid, 32'h1);
    chk("halt_pc", pc_out, 32'd121);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0003;
    cyc();
    chk("halt_valid_drop", ir_valid, 32'h0);
    chk("halt_pc_frozen", pc_out, 32'd121);
    stall = 1'b0; branch_taken = 1'b0;
    cyc(); cyc();

    // reset while halted
    reset = 1'b1; stall = 1'b1;
    cyc();
    chk("rst_halt_flag", halted, 32'h0);
    chk("rst_halt_pc", pc_out, 32'h0);
    reset = 1'b0; stall = 1'b0;
    cyc();

    // PC wrap
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    cyc();
    branch_taken = 1'b0;
    cyc();
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_ir_pc", ir_pc, 32'hFFFF);

    // reset while stalled
    stall = 1'b1;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk("rst_stall_valid", ir_valid, 32'h0);
    chk("rst_stall_cnt", fetch_count, 32'h0);
    reset = 1'b0; stall = 1'b0;

    // 2-bit counter saturation on the second instance
    @(negedge clk);
    reset2 = 1'b0; stall2 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("sat_cnt", fetch_count2, (i < 3) ? i : 3);
    end
    chk("sat_pc", pc_out2, 32'd5);
    reset2 = 1'b1;

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 99) < 3);
      stall        = ($urandom_range(0, 99) < 25);
      branch_taken = ($urandom_range(0, 99) < 10);
      branch_target = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                  : 16'($urandom_range(0, 255));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
